// File: rtl/writeback_if.sv
// Writeback bus: ALU/load result handshakes, register-file write port,
// queue control and forwarding paths.
interface writeback_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        alu_ready;

  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic [31:0] ld_word;
  logic        ld_ready;

  logic        regWrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic        flush;
  logic        wb_stall;

  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        fwd1_hit;
  logic [31:0] fwd1_data;
  logic        fwd2_hit;
  logic [31:0] fwd2_data;

  // Producer / pipeline side
  modport master (
    output alu_valid, alu_rd, alu_result,
    input  alu_ready,
    output ld_valid, ld_rd, ld_funct3, ld_addr_lo, ld_word,
    input  ld_ready,
    input  regWrite, wb_rd, wb_data,
    output flush, wb_stall,
    output rs1, rs2,
    input  fwd1_hit, fwd1_data, fwd2_hit, fwd2_data
  );

  // Writeback unit side
  modport slave (
    input  alu_valid, alu_rd, alu_result,
    output alu_ready,
    input  ld_valid, ld_rd, ld_funct3, ld_addr_lo, ld_word,
    output ld_ready,
    output regWrite, wb_rd, wb_data,
    input  flush, wb_stall,
    input  rs1, rs2,
    output fwd1_hit, fwd1_data, fwd2_hit, fwd2_data
  );
endinterface

// File: rtl/writeback_unit.sv
// Writeback unit: 2-entry result queue feeding the register-file write port,
// with load data extension, fixed load-over-ALU priority and forwarding.
module writeback_unit (
  input  logic       clk,
  input  logic       reset_n,
  writeback_if.slave wb
);
  localparam int unsigned RegW   = 5;
  localparam int unsigned DataW  = 32;
  localparam int unsigned CountW = 2;

  typedef struct packed {
    logic [RegW-1:0]  rd;
    logic [DataW-1:0] data;
  } entry_t;

  entry_t             mem_q [2];
  logic               wr_ptr_q;
  logic               rd_ptr_q;
  logic [CountW-1:0]  count_q;
  logic               reg_write_q;
  logic [RegW-1:0]    wb_rd_q;
  logic [DataW-1:0]   wb_data_q;
  logic               fwd1_hit_q, fwd2_hit_q;
  logic [DataW-1:0]   fwd1_data_q, fwd2_data_q;

  logic               not_full_c;
  logic               ld_fire_c, alu_fire_c;
  logic               push_c, pop_c;
  entry_t             push_entry_c;
  logic [7:0]         byte_c;
  logic [15:0]        half_c;
  logic [DataW-1:0]   ld_ext_c;

  // Readiness and transfer selection; a pending load blocks the ALU path
  always_comb begin
    not_full_c   = (count_q < CountW'(2)) && !wb.flush;
    wb.ld_ready  = not_full_c;
    wb.alu_ready = not_full_c && !wb.ld_valid;
    ld_fire_c    = wb.ld_valid && not_full_c;
    alu_fire_c   = wb.alu_valid && not_full_c && !wb.ld_valid;
    pop_c        = (count_q != CountW'(0)) && !wb.wb_stall && !wb.flush;
  end

  // Little-endian lane select and sign/zero extension of load data
  always_comb begin
    byte_c = wb.ld_word[7:0];
    case (wb.ld_addr_lo)
      2'd1:    byte_c = wb.ld_word[15:8];
      2'd2:    byte_c = wb.ld_word[23:16];
      2'd3:    byte_c = wb.ld_word[31:24];
      default: byte_c = wb.ld_word[7:0];
    endcase
    half_c = wb.ld_addr_lo[1] ? wb.ld_word[31:16] : wb.ld_word[15:0];
    case (wb.ld_funct3)
      3'b000:  ld_ext_c = {{24{byte_c[7]}}, byte_c};
      3'b001:  ld_ext_c = {{16{half_c[15]}}, half_c};
      3'b100:  ld_ext_c = {24'd0, byte_c};
      3'b101:  ld_ext_c = {16'd0, half_c};
      default: ld_ext_c = wb.ld_word;
    endcase
  end

  // Enqueue payload; transfers to x0 are accepted but dropped
  always_comb begin
    push_entry_c.rd   = ld_fire_c ? wb.ld_rd : wb.alu_rd;
    push_entry_c.data = ld_fire_c ? ld_ext_c : wb.alu_result;
    push_c            = (ld_fire_c || alu_fire_c) && (push_entry_c.rd != RegW'(0));
  end

  // Queue state, write port and forwarding registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= '0;
      reg_write_q <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      fwd1_hit_q  <= 1'b0;
      fwd2_hit_q  <= 1'b0;
      fwd1_data_q <= '0;
      fwd2_data_q <= '0;
    end else begin
      fwd1_hit_q  <= reg_write_q && (wb_rd_q == wb.rs1) && (wb.rs1 != RegW'(0));
      fwd2_hit_q  <= reg_write_q && (wb_rd_q == wb.rs2) && (wb.rs2 != RegW'(0));
      fwd1_data_q <= wb_data_q;
      fwd2_data_q <= wb_data_q;
      if (wb.flush) begin
        wr_ptr_q    <= 1'b0;
        rd_ptr_q    <= 1'b0;
        count_q     <= '0;
        reg_write_q <= 1'b0;
      end else begin
        if (push_c) begin
          mem_q[wr_ptr_q] <= push_entry_c;
          wr_ptr_q        <= ~wr_ptr_q;
        end
        if (pop_c) begin
          wb_rd_q   <= mem_q[rd_ptr_q].rd;
          wb_data_q <= mem_q[rd_ptr_q].data;
          rd_ptr_q  <= ~rd_ptr_q;
        end
        reg_write_q <= pop_c;
        count_q     <= count_q + CountW'(push_c) - CountW'(pop_c);
      end
    end
  end

  // Drive registered outputs onto the bus
  always_comb begin
    wb.regWrite  = reg_write_q;
    wb.wb_rd     = wb_rd_q;
    wb.wb_data   = wb_data_q;
    wb.fwd1_hit  = fwd1_hit_q;
    wb.fwd2_hit  = fwd2_hit_q;
    wb.fwd1_data = fwd1_data_q;
    wb.fwd2_data = fwd2_data_q;
  end
endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: table of single-result vectors plus directed
// multi-cycle sequences (priority, stall, forwarding, flush, reset).
module tb_writeback_unit;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  writeback_if wbi ();

  writeback_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wb      (wbi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_ld;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] word;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance one clock, settle just after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wbi.alu_valid  = 1'b0;
    wbi.alu_rd     = '0;
    wbi.alu_result = '0;
    wbi.ld_valid   = 1'b0;
    wbi.ld_rd      = '0;
    wbi.ld_funct3  = '0;
    wbi.ld_addr_lo = '0;
    wbi.ld_word    = '0;
  endtask

  task automatic alu_push(input logic [4:0] rd, input logic [31:0] d);
    wbi.alu_valid  = 1'b1;
    wbi.alu_rd     = rd;
    wbi.alu_result = d;
  endtask

  initial begin
    idle_inputs();
    wbi.flush    = 1'b0;
    wbi.wb_stall = 1'b0;
    wbi.rs1      = '0;
    wbi.rs2      = '0;

    vecs[0]  = '{1'b0, 3'b000, 2'd0, 32'h12345678, 5'd5,  32'h12345678};
    vecs[1]  = '{1'b1, 3'b000, 2'd2, 32'h80FF7F01, 5'd6,  32'hFFFFFFFF};
    vecs[2]  = '{1'b1, 3'b000, 2'd3, 32'h80FF7F01, 5'd7,  32'hFFFFFF80};
    vecs[3]  = '{1'b1, 3'b100, 2'd2, 32'h80FF7F01, 5'd8,  32'h000000FF};
    vecs[4]  = '{1'b1, 3'b101, 2'd2, 32'h80FF7F01, 5'd9,  32'h000080FF};
    vecs[5]  = '{1'b1, 3'b001, 2'd2, 32'h80FF7F01, 5'd10, 32'hFFFF80FF};
    vecs[6]  = '{1'b1, 3'b001, 2'd0, 32'h80FF7F01, 5'd11, 32'h00007F01};
    vecs[7]  = '{1'b1, 3'b010, 2'd1, 32'h80FF7F01, 5'd12, 32'h80FF7F01};
    vecs[8]  = '{1'b1, 3'b011, 2'd0, 32'h80FF7F01, 5'd13, 32'h80FF7F01};
    vecs[9]  = '{1'b1, 3'b100, 2'd0, 32'h80FF7F01, 5'd14, 32'h00000001};
    vecs[10] = '{1'b1, 3'b000, 2'd1, 32'h80FF7F01, 5'd15, 32'h0000007F};
    vecs[11] = '{1'b1, 3'b101, 2'd0, 32'h0000F00D, 5'd31, 32'h0000F00D};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_regWrite", 32'(wbi.regWrite), 32'd0);
    chk("rst_wb_rd",    32'(wbi.wb_rd),    32'd0);
    chk("rst_wb_data",  wbi.wb_data,       32'd0);
    chk("rst_fwd1_hit", 32'(wbi.fwd1_hit), 32'd0);
    chk("rst_fwd2_hit", 32'(wbi.fwd2_hit), 32'd0);
    chk("rst_fwd1_data", wbi.fwd1_data,    32'd0);
    chk("rst_fwd2_data", wbi.fwd2_data,    32'd0);
    reset_n = 1'b1;
    tick();
    chk("post_rst_ld_ready",  32'(wbi.ld_ready),  32'd1);
    chk("post_rst_alu_ready", 32'(wbi.alu_ready), 32'd1);

    // Single transfers: accepted at edge N, written after N+1, then idle
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].is_ld) begin
        wbi.ld_valid   = 1'b1;
        wbi.ld_rd      = vecs[i].rd;
        wbi.ld_funct3  = vecs[i].f3;
        wbi.ld_addr_lo = vecs[i].lo;
        wbi.ld_word    = vecs[i].word;
      end else begin
        alu_push(vecs[i].rd, vecs[i].word);
      end
      tick();
      idle_inputs();
      chk($sformatf("v%0d_early_regWrite", i), 32'(wbi.regWrite), 32'd0);
      tick();
      chk($sformatf("v%0d_regWrite", i), 32'(wbi.regWrite), 32'd1);
      chk($sformatf("v%0d_wb_rd", i),    32'(wbi.wb_rd),    32'(vecs[i].rd));
      chk($sformatf("v%0d_wb_data", i),  wbi.wb_data,       vecs[i].exp);
      tick();
      chk($sformatf("v%0d_after_regWrite", i), 32'(wbi.regWrite), 32'd0);
    end

    // Load wins over ALU; ALU follows one cycle later
    wbi.ld_valid  = 1'b1;
    wbi.ld_rd     = 5'd3;
    wbi.ld_funct3 = 3'b010;
    wbi.ld_word   = 32'h11111111;
    alu_push(5'd4, 32'h22222222);
    #1;
    chk("prio_ld_ready",  32'(wbi.ld_ready),  32'd1);
    chk("prio_alu_ready", 32'(wbi.alu_ready), 32'd0);
    tick();
    wbi.ld_valid = 1'b0;
    #1;
    chk("prio_alu_ready2", 32'(wbi.alu_ready), 32'd1);
    tick();
    wbi.alu_valid = 1'b0;
    chk("prio_w1_regWrite", 32'(wbi.regWrite), 32'd1);
    chk("prio_w1_rd",       32'(wbi.wb_rd),    32'd3);
    chk("prio_w1_data",     wbi.wb_data,       32'h11111111);
    tick();
    chk("prio_w2_regWrite", 32'(wbi.regWrite), 32'd1);
    chk("prio_w2_rd",       32'(wbi.wb_rd),    32'd4);
    chk("prio_w2_data",     wbi.wb_data,       32'h22222222);
    tick();
    chk("prio_idle", 32'(wbi.regWrite), 32'd0);

    // Stall for 3 cycles while two results queue up, then drain in order
    wbi.wb_stall = 1'b1;
    alu_push(5'd8, 32'h00000088);
    tick();
    alu_push(5'd9, 32'h00000099);
    tick();
    idle_inputs();
    #1;
    chk("stall_ld_ready",  32'(wbi.ld_ready),  32'd0);
    chk("stall_alu_ready", 32'(wbi.alu_ready), 32'd0);
    chk("stall_regWrite",  32'(wbi.regWrite),  32'd0);
    tick();
    chk("stall3_regWrite", 32'(wbi.regWrite),  32'd0);
    chk("stall3_ld_ready", 32'(wbi.ld_ready),  32'd0);
    wbi.wb_stall = 1'b0;
    tick();
    chk("drain1_regWrite", 32'(wbi.regWrite), 32'd1);
    chk("drain1_rd",       32'(wbi.wb_rd),    32'd8);
    chk("drain1_data",     wbi.wb_data,       32'h00000088);
    chk("drain1_ld_ready", 32'(wbi.ld_ready), 32'd1);
    tick();
    chk("drain2_regWrite", 32'(wbi.regWrite), 32'd1);
    chk("drain2_rd",       32'(wbi.wb_rd),    32'd9);
    chk("drain2_data",     wbi.wb_data,       32'h00000099);
    tick();
    chk("drain_idle", 32'(wbi.regWrite), 32'd0);

    // Forwarding on a write to x7, then an x0 transfer that must not write
    wbi.rs1 = 5'd7;
    wbi.rs2 = 5'd7;
    alu_push(5'd7, 32'h000000A5);
    tick();
    idle_inputs();
    tick();
    chk("fwd_w_regWrite", 32'(wbi.regWrite), 32'd1);
    chk("fwd_w_rd",       32'(wbi.wb_rd),    32'd7);
    tick();
    chk("fwd1_hit",  32'(wbi.fwd1_hit), 32'd1);
    chk("fwd2_hit",  32'(wbi.fwd2_hit), 32'd1);
    chk("fwd1_data", wbi.fwd1_data,     32'h000000A5);
    chk("fwd2_data", wbi.fwd2_data,     32'h000000A5);
    alu_push(5'd0, 32'hDEADBEEF);
    #1;
    chk("x0_alu_ready", 32'(wbi.alu_ready), 32'd1);
    tick();
    idle_inputs();
    chk("x0_fwd1_clear", 32'(wbi.fwd1_hit), 32'd0);
    tick();
    chk("x0_no_write", 32'(wbi.regWrite), 32'd0);
    tick();
    chk("x0_no_write2", 32'(wbi.regWrite), 32'd0);
    chk("x0_fwd1_hit",  32'(wbi.fwd1_hit), 32'd0);
    wbi.rs1 = '0;
    wbi.rs2 = '0;

    // Flush with a full queue discards both entries
    wbi.wb_stall = 1'b1;
    alu_push(5'd20, 32'h00000020);
    tick();
    alu_push(5'd21, 32'h00000021);
    tick();
    idle_inputs();
    wbi.flush = 1'b1;
    #1;
    chk("flush_full_ready", 32'(wbi.ld_ready), 32'd0);
    tick();
    wbi.flush    = 1'b0;
    wbi.wb_stall = 1'b0;
    #1;
    chk("flush_regWrite", 32'(wbi.regWrite), 32'd0);
    chk("flush_ld_ready", 32'(wbi.ld_ready), 32'd1);
    tick();
    chk("flush_no_write1", 32'(wbi.regWrite), 32'd0);
    tick();
    chk("flush_no_write2", 32'(wbi.regWrite), 32'd0);

    // Asynchronous reset in the middle of a drain
    wbi.wb_stall = 1'b1;
    alu_push(5'd22, 32'h00000022);
    tick();
    alu_push(5'd23, 32'h00000023);
    tick();
    idle_inputs();
    wbi.wb_stall = 1'b0;
    tick();
    chk("mid_w1_regWrite", 32'(wbi.regWrite), 32'd1);
    chk("mid_w1_rd",       32'(wbi.wb_rd),    32'd22);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_regWrite", 32'(wbi.regWrite), 32'd0);
    chk("arst_wb_data",  wbi.wb_data,       32'd0);
    tick();
    reset_n = 1'b1;
    #1;
    chk("arst_ready", 32'(wbi.ld_ready), 32'd1);
    tick();
    chk("arst_no_stale1", 32'(wbi.regWrite), 32'd0);
    tick();
    chk("arst_no_stale2", 32'(wbi.regWrite), 32'd0);
    chk("arst_wb_rd",     32'(wbi.wb_rd),    32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
